// File: rtl/stb_strobe_gen.sv
// rtl/stb_strobe_gen.sv - STB strobe transmitter: one active-low pulse of
// programmable width followed by a guard high interval.
module stb_strobe_gen #(
  parameter int CNT_W   = 8,
  parameter int MIN_GAP = 9,
  parameter int PCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  low_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic              abort,
  output logic              STB,
  output logic              ready,
  output logic              done,
  output logic              aborted,
  output logic [PCNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_GAP_V  = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0]  MIN_GAP_M1 = CNT_W'(MIN_GAP - 1);
  localparam logic [PCNT_W-1:0] PONE       = PCNT_W'(1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  gap_m1, gap_m1_n;
  logic              abt, abt_n;
  logic              stb_n, ready_n, done_n, aborted_n;
  logic [PCNT_W-1:0] pcnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_m1    <= '0;
      abt       <= 1'b0;
      STB       <= 1'b1;
      ready     <= 1'b1;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap_m1    <= gap_m1_n;
      abt       <= abt_n;
      STB       <= stb_n;
      ready     <= ready_n;
      done      <= done_n;
      aborted   <= aborted_n;
      pulse_cnt <= pcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gap_m1_n  = gap_m1;
    abt_n     = abt;
    stb_n     = STB;
    ready_n   = ready;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    pcnt_n    = pulse_cnt;
    case (state)
      IDLE: begin
        stb_n   = 1'b1;
        ready_n = 1'b1;
        abt_n   = 1'b0;
        if (start) begin
          // Both lengths are stored as count-minus-one so the full range never wraps.
          cnt_n    = (low_len == '0) ? '0 : low_len - ONE;
          gap_m1_n = ((gap_len > MIN_GAP_V) ? gap_len : MIN_GAP_V) - ONE;
          stb_n    = 1'b0;
          ready_n  = 1'b0;
          state_n  = LOW;
        end
      end
      LOW: begin
        if (abort) begin
          stb_n   = 1'b1;
          cnt_n   = MIN_GAP_M1;
          abt_n   = 1'b1;
          state_n = GAP;
        end else if (cnt == '0) begin
          stb_n   = 1'b1;
          cnt_n   = gap_m1;
          state_n = GAP;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          ready_n = 1'b1;
          abt_n   = 1'b0;
          if (abt) begin
            aborted_n = 1'b1;
          end else begin
            done_n = 1'b1;
            pcnt_n = pulse_cnt + PONE;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = '0;
        gap_m1_n = '0;
        abt_n    = 1'b0;
        stb_n    = 1'b1;
        ready_n  = 1'b1;
        pcnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_stb_strobe_gen.sv
// tb/tb_stb_strobe_gen.sv - self-checking bench for stb_strobe_gen.
module tb_stb_strobe_gen;

  localparam int CNT_W   = 8;
  localparam int MIN_GAP = 9;
  localparam int PCNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] low_len = '0;
  logic [CNT_W-1:0] gap_len = '0;
  logic             STB, ready, done, aborted;
  logic [PCNT_W-1:0] pulse_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int ll;
    int gl;
    int ab_low;
    bit ab_start;
    bit ab_gap;
    int exp_low;
    int exp_gap;
    bit exp_abort;
  } vec_t;

  typedef struct {
    int          low;
    int          gap;
    bit          is_abort;
    logic [PCNT_W-1:0] pcnt;
  } exp_t;

  exp_t              sb[$];
  logic [PCNT_W-1:0] model_pcnt = '0;

  stb_strobe_gen #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .low_len(low_len), .gap_len(gap_len),
    .abort(abort), .STB(STB), .ready(ready), .done(done), .aborted(aborted),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (ready !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic run_pulse(input vec_t v);
    int   lows = 0;
    int   highs = 0;
    int   guard = 0;
    exp_t e;
    wait_ready();
    e.low      = v.exp_low;
    e.gap      = v.exp_gap;
    e.is_abort = v.exp_abort;
    e.pcnt     = v.exp_abort ? model_pcnt : model_pcnt + 1'b1;
    model_pcnt = e.pcnt;
    sb.push_back(e);
    low_len = CNT_W'(v.ll);
    gap_len = CNT_W'(v.gl);
    start   = 1'b1;
    abort   = v.ab_start;
    @(posedge clk);
    #1;
    start   = 1'b0;
    abort   = 1'b0;
    low_len = 8'd200;
    gap_len = 8'd200;
    @(negedge clk);
    while (STB === 1'b0 && guard < 600) begin
      lows++;
      if (lows == v.ab_low) abort = 1'b1;
      @(negedge clk);
      guard++;
    end
    abort = v.ab_gap;
    while (STB === 1'b1 && done !== 1'b1 && aborted !== 1'b1 && guard < 600) begin
      highs++;
      @(negedge clk);
      guard++;
    end
    abort = 1'b0;
    check("cycle_bound", 32'(guard < 600), 32'd1);
    check("low_width", 32'(lows), 32'(v.exp_low));
    check("gap_width", 32'(highs), 32'(v.exp_gap));
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("done_flag", 32'(done), 32'(!e.is_abort));
      check("aborted_flag", 32'(aborted), 32'(e.is_abort));
      check("pulse_cnt", 32'(pulse_cnt), 32'(e.pcnt));
      check("ready_back", 32'(ready), 32'd1);
      check("stb_idle", 32'(STB), 32'd1);
    end
    @(negedge clk);
    check("flags_one_cycle", 32'({done, aborted}), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t short_v;

  initial begin
    int   lows;
    int   highs;
    int   guard;
    int   iter;
    bit   seen;
    exp_t e;

    vecs[0]  = '{4,   12,  0, 0, 0, 4,   12,  0};
    vecs[1]  = '{0,   2,   0, 0, 0, 1,   9,   0};
    vecs[2]  = '{10,  20,  3, 0, 0, 3,   9,   1};
    vecs[3]  = '{6,   30,  6, 0, 0, 6,   9,   1};
    vecs[4]  = '{1,   9,   0, 0, 0, 1,   9,   0};
    vecs[5]  = '{5,   0,   0, 0, 0, 5,   9,   0};
    vecs[6]  = '{4,   10,  0, 1, 0, 4,   10,  0};
    vecs[7]  = '{2,   11,  0, 0, 1, 2,   11,  0};
    vecs[8]  = '{2,   10,  1, 0, 0, 1,   9,   1};
    vecs[9]  = '{255, 255, 0, 0, 0, 255, 255, 0};
    vecs[10] = '{3,   1,   0, 0, 0, 3,   9,   0};
    short_v  = '{1,   0,   0, 0, 0, 1,   9,   0};

    repeat (2) @(negedge clk);
    check("rst_stb", 32'(STB), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_flags", 32'({done, aborted}), 32'd0);
    check("rst_pcnt", 32'(pulse_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_pulse(vecs[i]);

    // Start held high: the next pulse is accepted on the edge where done is high,
    // so STB is high for the guard plus that one idle cycle.
    wait_ready();
    for (int i = 0; i < 2; i++) begin
      e.low = 3; e.gap = 9; e.is_abort = 1'b0;
      e.pcnt = model_pcnt + 1'b1;
      model_pcnt = e.pcnt;
      sb.push_back(e);
    end
    low_len = 8'd3;
    gap_len = 8'd9;
    start   = 1'b1;
    @(posedge clk);
    #1;
    guard = 0;
    lows  = 0;
    @(negedge clk);
    while (STB === 1'b0 && guard < 200) begin lows++; @(negedge clk); guard++; end
    check("b2b_low1", 32'(lows), 32'd3);
    highs = 0;
    seen  = 1'b0;
    while (STB === 1'b1 && guard < 200) begin
      highs++;
      if (done === 1'b1 && sb.size() > 0) begin
        seen = 1'b1;
        e = sb.pop_front();
        check("b2b_pcnt1", 32'(pulse_cnt), 32'(e.pcnt));
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("b2b_high", 32'(highs), 32'd10);
    check("b2b_done_seen", 32'(seen), 32'd1);
    lows = 0;
    while (STB === 1'b0 && guard < 200) begin lows++; @(negedge clk); guard++; end
    check("b2b_low2", 32'(lows), 32'd3);
    highs = 0;
    while (STB === 1'b1 && done !== 1'b1 && guard < 200) begin highs++; @(negedge clk); guard++; end
    check("b2b_gap2", 32'(highs), 32'd9);
    check("b2b_done2", 32'(done), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("b2b_pcnt2", 32'(pulse_cnt), 32'(e.pcnt));
    end else begin
      check("b2b_sb", 32'd0, 32'd1);
    end
    @(negedge clk);

    iter = 0;
    while (model_pcnt != 4'd15 && iter < 20) begin
      run_pulse(short_v);
      iter++;
    end
    check("pre_wrap", 32'(pulse_cnt), 32'd15);
    run_pulse(short_v);
    check("wrap_to_zero", 32'(pulse_cnt), 32'd0);

    wait_ready();
    low_len = 8'd20;
    gap_len = 8'd9;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_low_stb", 32'(STB), 32'd0);
    rst = 1'b0;
    #1;
    check("async_rst_stb", 32'(STB), 32'd1);
    check("async_rst_ready", 32'(ready), 32'd1);
    check("async_rst_flags", 32'({done, aborted}), 32'd0);
    check("async_rst_pcnt", 32'(pulse_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_pcnt = '0;
    sb.delete();
    @(negedge clk);
    run_pulse(vecs[0]);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
